muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit that owns the HI/LO registers in the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and produces HI/LO for MFHI/MFLO.
- Drives the busy flag that the hazard/stall unit consumes as isbusy. The stall unit combines it with RHL_visit to hold IF/ID while a result is pending.

Parameters:
MUL_LAT, 3, multiply latency in cycles spent in state MUL (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  EX-stage instruction valid with a MDU op this cycle
MDUOp  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
flush  input  1  MEM_ex | MEM_eret_flush; cancels the EX-stage op and any in-flight op
A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
B  input  32  rt operand (divisor / multiplier)
busy  output  1  result pending; to stall unit isbusy
done  output  1  one-cycle pulse in the cycle HI/LO are updated by MUL/DIV
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, any state): state=IDLE, HI=0, LO=0, done=0, counter=0, operand/partial registers=0.
- States: IDLE, MUL, DIV.
- Accept rule: accept = start & ~flush & (state==IDLE).
  - start while not IDLE is ignored; the stall unit guarantees this cannot occur for valid code.
- busy is combinational: busy = (state!=IDLE) | (accept & MDUOp in {MULT,MULTU,DIV,DIVU}).
  - This makes an MFHI/MFLO immediately behind a MULT/DIV stall in the same cycle the MULT/DIV is in EX.
- MTHI/MTLO on accept: write HI (resp. LO) with A at the clock edge. Takes one cycle, busy stays 0, done stays 0.
- MULT/MULTU on accept (cycle t):
  - Latch the 64-bit product into a holding register: signed for MULT, unsigned for MULTU.
  - Enter MUL with counter=0.
  - Leave MUL after MUL_LAT cycles, at the edge ending cycle t+MUL_LAT: {HI,LO}=product, done=1 in cycle t+MUL_LAT.
  - busy=1 for cycles t..t+MUL_LAT. The new HI/LO is visible from cycle t+MUL_LAT+1.
- DIV/DIVU on accept (cycle t):
  - Latch |A|, |B| (DIVU: raw values), sign_q=A[31]^B[31] and sign_r=A[31] (DIV only).
  - Radix-2 restoring division: one quotient bit per cycle, 32 cycles in DIV (t+1..t+32).
  - At the edge ending t+32, write LO=quotient and HI=remainder, sign-corrected for DIV: negate quotient if sign_q, negate remainder if sign_r.
  - done=1 in cycle t+32; busy=1 for t..t+32.
  - Magnitude of 0x80000000 is computed as 33-bit, so -2^31 operands are exact.
  - 0x80000000 / -1 (DIV) gives LO=0x80000000, HI=0.
- Divide by zero (DIV and DIVU), full latency: LO=0xFFFFFFFF, HI=A (raw, no sign correction).
- flush:
  - With start in the same cycle: op suppressed, no state change.
  - While MUL/DIV is in flight: return to IDLE next edge, HI/LO unchanged, done=0, busy drops in the following cycle.
- Simultaneous completion and start: cannot accept, because state!=IDLE in the completion cycle; the next op is accepted in the following cycle.
- HI/LO are written only on an MTHI/MTLO accept or on MUL/DIV completion.

Optional Feature:
MDU_DIV_EARLY_EN
- Defined: DIV/DIVU completes after one cycle in DIV (done at t+1, HI/LO visible at t+2) when the divisor is zero or |A|<|B|.
  - Divisor zero: results as in the divide-by-zero rule.
  - |A|<|B|: LO=0, HI=A.
- Not defined: every divide takes the full 32 cycles.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF at t (MUL_LAT=3) -> busy 1 for t..t+3, done at t+3, HI=0xFFFFFFFE LO=0x00000001 at t+4.
- MULT with same operands -> HI=0x00000000, LO=0x00000001.
- DIV A=-7 (0xFFFFFFF9) B=2 -> after 32 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF, done exactly at t+32.
- DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=100.
  - With MDU_DIV_EARLY_EN: done at t+1.
  - Without: done at t+32.
- MTLO A=0x12345678 with busy=0 -> LO=0x12345678 next cycle, busy and done never assert. Then start+flush with MULT -> no busy, HI/LO unchanged.
- DIVU in flight, flush at t+10 -> state IDLE at t+11, busy 0, HI/LO keep prior values. Then assert rst at t+5 of a new DIV -> HI=LO=0 and busy=0 immediately.

Source files
------------

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
//            Optional macro MDU_DIV_EARLY_EN: one-cycle divide when the divisor
//            is zero or |A| < |B|.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_mul      = 2'd1;
    localparam logic [1:0] c_div      = 2'd2;
    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;
    localparam logic [4:0] c_mul_last = 5'(MUL_LAT - 1);
    localparam logic [4:0] c_div_last = 5'd31;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_prod;
    logic [31:0] r_rem, r_quo, r_dvsr, r_a_raw;
    logic        r_sign_q, r_sign_r, r_dz, r_early;
    logic [31:0] r_hi, r_lo;

    logic        w_accept, w_is_mul, w_is_div, w_signed, w_early_c;
    logic        w_mul_last, w_div_last;
    logic [63:0] w_ax, w_bx, w_prod;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_shift, w_diff;
    logic [31:0] w_rem_nx, w_quo_nx, w_hi_div, w_lo_div;

    assign w_accept = start & ~flush & (r_state == c_idle);
    assign w_is_mul = (MDUOp == c_op_mult) | (MDUOp == c_op_multu);
    assign w_is_div = (MDUOp == c_op_div) | (MDUOp == c_op_divu);
    assign w_signed = (MDUOp == c_op_mult) | (MDUOp == c_op_div);

    assign busy = (r_state != c_idle) | (w_accept & (w_is_mul | w_is_div));

    // Extend to 64 bits first so one multiplier serves both signednesses.
    assign w_ax   = w_signed ? {{32{A[31]}}, A} : {32'd0, A};
    assign w_bx   = w_signed ? {{32{B[31]}}, B} : {32'd0, B};
    assign w_prod = w_ax * w_bx;

    // Negating 0x80000000 yields 0x80000000, which is exact as an unsigned magnitude.
    assign w_a_mag = (w_signed & A[31]) ? (32'd0 - A) : A;
    assign w_b_mag = (w_signed & B[31]) ? (32'd0 - B) : B;

`ifdef MDU_DIV_EARLY_EN
    assign w_early_c = (B == 32'd0) | (w_a_mag < w_b_mag);
`else
    assign w_early_c = 1'b0;
`endif

    // Restoring step: shift next dividend bit into the partial remainder and try a subtract.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = w_shift - {1'b0, r_dvsr};
    assign w_rem_nx = w_diff[32] ? w_shift[31:0] : w_diff[31:0];
    assign w_quo_nx = {r_quo[30:0], ~w_diff[32]};

    assign w_lo_div = r_dz    ? 32'hFFFF_FFFF :
                      r_early ? 32'd0 :
                      (r_sign_q ? (32'd0 - w_quo_nx) : w_quo_nx);
    assign w_hi_div = (r_dz | r_early) ? r_a_raw :
                      (r_sign_r ? (32'd0 - w_rem_nx) : w_rem_nx);

    assign w_mul_last = (r_state == c_mul) & (r_cnt == c_mul_last);
    assign w_div_last = (r_state == c_div) & ((r_cnt == c_div_last) | r_early);
    assign done       = ~flush & (w_mul_last | w_div_last);

    assign HI = r_hi;
    assign LO = r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_cnt    <= 5'd0;
            r_prod   <= 64'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_dvsr   <= 32'd0;
            r_a_raw  <= 32'd0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dz     <= 1'b0;
            r_early  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_prod  <= w_prod;
                            r_cnt   <= 5'd0;
                            r_state <= c_mul;
                        end else if (w_is_div) begin
                            r_quo    <= w_a_mag;
                            r_dvsr   <= w_b_mag;
                            r_rem    <= 32'd0;
                            r_a_raw  <= A;
                            r_sign_q <= w_signed & (A[31] ^ B[31]);
                            r_sign_r <= w_signed & A[31];
                            r_dz     <= (B == 32'd0);
                            r_early  <= w_early_c;
                            r_cnt    <= 5'd0;
                            r_state  <= c_div;
                        end else if (MDUOp == c_op_mthi) begin
                            r_hi <= A;
                        end else if (MDUOp == c_op_mtlo) begin
                            r_lo <= A;
                        end
                    end
                end
                c_mul: begin
                    if (flush) begin
                        r_state <= c_idle;
                    end else if (w_mul_last) begin
                        r_hi    <= r_prod[63:32];
                        r_lo    <= r_prod[31:0];
                        r_state <= c_idle;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                c_div: begin
                    if (flush) begin
                        r_state <= c_idle;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + 5'd1;
                        if (w_div_last) begin
                            r_hi    <= w_hi_div;
                            r_lo    <= w_lo_div;
                            r_state <= c_idle;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit (directed vector table plus
//            hand-written flush / reset / back-to-back sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam int LAT = 3;
`ifdef MDU_DIV_EARLY_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  MDUOp = 3'd0;
    logic        flush = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_pass = 0;
    int n_tot  = 0;

    muldiv_unit #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .MDUOp(MDUOp), .flush(flush),
        .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat_seen;
        logic busy_ok;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        start = 1'b1; MDUOp = v.op; A = v.a; B = v.b;
        #1 chk({tag, "_busy_t"}, 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0; A = 32'd0; B = 32'd0;
        lat_seen = -1;
        busy_ok  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat_seen = k;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(lat_seen), 64'(v.lat));
        chk({tag, "_busy_hold"}, 64'(busy_ok), 64'd1);
        @(negedge clk);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(HI), 64'(v.hi));
        chk({tag, "_lo"}, 64'(LO), 64'(v.lo));
    endtask

    initial begin
        logic seen;
        int   d1, d2;

        vecs[0]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, LAT};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, LAT};
        vecs[3]  = '{3'd2, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, LAT};
        vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32};
        vecs[5]  = '{3'd4, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, EARLY_LAT};
        vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32};
        vecs[7]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 32};
        vecs[8]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 32};
        vecs[9]  = '{3'd3, 32'd3,         32'd5,         32'd3,         32'd0,         EARLY_LAT};
        vecs[10] = '{3'd3, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, EARLY_LAT};
        vecs[11] = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        // MTLO / MTHI
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd6; A = 32'h1234_5678;
        #1 chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);
        @(negedge clk);
        MDUOp = 3'd5; A = 32'hCAFE_BABE;
        chk("mtlo_lo", 64'(LO), 64'h1234_5678);
        #1 chk("mthi_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0; A = 32'd0;
        chk("mthi_hi", 64'(HI), 64'hCAFE_BABE);
        chk("mthi_done", 64'(done), 64'd0);

        // start with flush in the same cycle is suppressed
        start = 1'b1; flush = 1'b1; MDUOp = 3'd1; A = 32'd9; B = 32'd9;
        #1 chk("sflush_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0; MDUOp = 3'd0;
        seen = 1'b0;
        repeat (LAT + 2) begin
            if (busy || done) seen = 1'b1;
            @(negedge clk);
        end
        chk("sflush_quiet", 64'(seen), 64'd0);
        chk("sflush_hilo", {HI, LO}, {32'hCAFE_BABE, 32'h1234_5678});

        // DIVU flushed at t+10
        start = 1'b1; MDUOp = 3'd4; A = 32'd1000; B = 32'd7;
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1 chk("iflush_done", 64'(done), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("iflush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (30) begin
            if (busy || done) seen = 1'b1;
            @(negedge clk);
        end
        chk("iflush_quiet", 64'(seen), 64'd0);
        chk("iflush_hilo", {HI, LO}, {32'hCAFE_BABE, 32'h1234_5678});

        // Directed vector table
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // start held through completion: second op accepted the cycle after done
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd2; A = 32'd3; B = 32'd5;
        d1 = -1; d2 = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin A = 32'd7; B = 32'd11; end
            if (k == LAT + 2) begin start = 1'b0; MDUOp = 3'd0; end
            if (done && d1 < 0) d1 = k;
            else if (done && d2 < 0) d2 = k;
        end
        chk("b2b_first_done", 64'(d1), 64'(LAT));
        chk("b2b_second_done", 64'(d2), 64'(2 * LAT + 1));
        chk("b2b_hilo", {HI, LO}, {32'd0, 32'd77});

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd3; A = 32'd50; B = 32'd3;
        @(negedge clk);
        start = 1'b0; MDUOp = 3'd0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("arst_hilo", {HI, LO}, 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_stay_idle", 64'({busy, done}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
